frame_addr_gen: RTL and testbench
=================================

Name: frame_addr_gen

Overview:
Parametrised successor to the camera write-address generator. Converts a (line, pixel, data, we) pixel stream into linear frame-buffer write addresses. Adds a crop window with origin offsets, a runtime row stride, optional 2x decimation, and double-buffered banks that swap at frame end. Per-frame pixel count and overflow status are provided for the IPM/readout side. The block sits between the camera/transform stream and the main frame-buffer BRAM.

Parameters:
DATA_W, 12, pixel data width
LINE_W, 9, line index width
PIXEL_W, 10, pixel index width
ADDR_W, 18, memory address width; must hold 2*BANK_DEPTH-1
BANK_DEPTH, 76800, words per bank; bank A base is 0, bank B base is BANK_DEPTH
DEF_WIDTH, 320, reset value of the shadow width and stride
DEF_DEPTH, 240, reset value of the shadow depth

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_we  in  1  input pixel valid / write request
i_data  in  DATA_W  pixel data
i_line  in  LINE_W  line index of the pixel
i_pixel  in  PIXEL_W  pixel index within the line
i_frame_end  in  1  one-cycle pulse marking the last cycle of a frame
i_x0  in  PIXEL_W  crop origin, pixel
i_y0  in  LINE_W  crop origin, line
i_imag_width  in  PIXEL_W  crop width, in source pixels
i_imag_depth  in  LINE_W  crop depth, in source lines
i_stride  in  PIXEL_W  row stride of the stored image, in words
i_mode  in  1  0 = full resolution, 1 = 2x decimation
i_swap_en  in  1  1 = double buffering, 0 = always bank A
o_we  out  1  memory write enable
o_data  out  DATA_W  memory write data
o_addr  out  ADDR_W  memory write address
o_wr_bank  out  1  bank currently being written
o_rd_bank  out  1  bank safe to read (~o_wr_bank when swapping, else 0)
o_frame_done  out  1  one-cycle pulse after each frame end
o_pix_count  out  ADDR_W  number of writes in the completed frame
o_overflow  out  1  sticky flag: a write was dropped for exceeding BANK_DEPTH

Behaviour:
- Reset (async, rst_n low): all outputs 0. Pipeline valid bits, counters and bank = 0. Shadow config set to x0=0, y0=0, width=DEF_WIDTH, depth=DEF_DEPTH, stride=DEF_WIDTH, mode=0, swap_en=0.
- Shadow config: the i_x0..i_swap_en inputs are sampled into shadow registers only on the cycle i_frame_end=1. All address math uses the shadow values, so config changes mid-frame have no effect until the next frame.
- Stage 1 (cycle N+1):
  - rx = i_pixel-i_x0, ry = i_line-i_y0.
  - Accept iff i_we=1, i_pixel>=x0, rx<width, i_line>=y0, ry<depth, and (mode=0 or (rx[0]=0 and ry[0]=0)).
  - Register v1, data, col = mode ? rx>>1 : rx, row_off = (mode ? ry>>1 : ry) * stride (ADDR_W bits, unsigned), and bank_at_capture.
- Stage 2 (cycle N+2):
  - off = row_off + col.
  - If v1 and off < BANK_DEPTH: o_we=1, o_addr = off + (bank ? BANK_DEPTH : 0), o_data = data.
  - If v1 and off >= BANK_DEPTH: o_we=0 and o_overflow<=1.
  - Otherwise o_we=0, o_addr=0, o_data=0.
- Latency: exactly 2 cycles from input to o_we. Throughput: 1 pixel per cycle, no backpressure.
- Frame end:
  - A pixel presented in the same cycle as i_frame_end belongs to the ending frame and uses the old bank. The bank toggles on the following edge only if the newly sampled swap_en=1; otherwise bank is forced to 0.
  - In-flight stage-1/stage-2 writes keep their captured bank.
  - o_frame_done pulses 2 cycles after i_frame_end so that all writes of the frame have been issued. o_pix_count is loaded with the write count on that same cycle; the write counter restarts from 0, or from 1 if the first write of the next frame coincides.
  - o_overflow clears on o_frame_done unless an overflow occurs in that same cycle (set wins).
- o_rd_bank = swap_en_shadow ? ~o_wr_bank : 0.
- Arithmetic: all unsigned. Width/depth compares use rx/ry, so there is no x0+width overflow. The pixel counter saturates at 2^ADDR_W-1.

Test Plan:
- Reset, then i_we=1, line=2, pixel=5 -> 2 cycles later o_we=1, o_addr=645, o_wr_bank=0.
- Config x0=10, y0=4, width=100, depth=50, stride=100, then i_frame_end. Then pixel(9,4) -> no write; (10,4) -> addr 0; (109,53) -> addr 4999; (110,53) -> no write.
- mode=1, stride=160, frame_end. Then (1,0) -> dropped; (6,4) -> addr 323; a frame of 320x240 -> o_pix_count=19200.
- swap_en=1, default geometry. A frame_end coincident with a write at (0,0) -> addr 0 (bank A). The next frame's (0,0) -> addr 76800, o_rd_bank=0, o_frame_done pulses once with the previous frame's count.
- width=400, stride=400, depth=240. Line 192, pixel 0 -> o_we=0, o_overflow=1, held until the next o_frame_done.
- rst_n low while stage 1 holds a valid pixel -> o_we=0 asynchronously. After release, no write appears and the shadow config is back at the defaults.

Source files
------------

// File: rtl/frame_addr_gen.sv
// Frame-buffer write-address generator.
// Turns a (line, pixel, data, we) stream into linear write addresses inside a
// crop window, with optional 2x decimation, runtime row stride and
// double-buffered banks that swap at frame end. Two-cycle pipeline, one pixel
// per cycle, no backpressure.
module frame_addr_gen #(
  parameter int DATA_W     = 12,
  parameter int LINE_W     = 9,
  parameter int PIXEL_W    = 10,
  parameter int ADDR_W     = 18,
  parameter int BANK_DEPTH = 76800,
  parameter int DEF_WIDTH  = 320,
  parameter int DEF_DEPTH  = 240
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_we,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [LINE_W-1:0]  i_line,
  input  logic [PIXEL_W-1:0] i_pixel,
  input  logic               i_frame_end,
  input  logic [PIXEL_W-1:0] i_x0,
  input  logic [LINE_W-1:0]  i_y0,
  input  logic [PIXEL_W-1:0] i_imag_width,
  input  logic [LINE_W-1:0]  i_imag_depth,
  input  logic [PIXEL_W-1:0] i_stride,
  input  logic               i_mode,
  input  logic               i_swap_en,
  output logic               o_we,
  output logic [DATA_W-1:0]  o_data,
  output logic [ADDR_W-1:0]  o_addr,
  output logic               o_wr_bank,
  output logic               o_rd_bank,
  output logic               o_frame_done,
  output logic [ADDR_W-1:0]  o_pix_count,
  output logic               o_overflow
);

  localparam logic [ADDR_W-1:0] BANK_B_BASE = ADDR_W'(BANK_DEPTH);

  // shadow configuration and current write bank
  logic [PIXEL_W-1:0] x0_q, width_q, stride_q;
  logic [LINE_W-1:0]  y0_q, depth_q;
  logic               mode_q, swap_q, bank_q;

  // stage 1
  logic               v1_q, bank1_q;
  logic [DATA_W-1:0]  data1_q;
  logic [PIXEL_W-1:0] col_q;
  logic [ADDR_W-1:0]  row_off_q;

  // stage 2 / status
  logic               we_q, done_q, ovf_q, fe1_q;
  logic [DATA_W-1:0]  data_q;
  logic [ADDR_W-1:0]  addr_q, cnt_q, pix_count_q;

  // combinational
  logic [PIXEL_W-1:0] rx, col_d;
  logic [LINE_W-1:0]  ry, ry_eff;
  logic               accept;
  logic [ADDR_W-1:0]  row_off_d;
  logic [ADDR_W-1:0]  off, addr_d, cnt_inc, cnt_d, pix_count_d;
  logic               in_range, we_d, ovf_set, ovf_d;
  logic [DATA_W-1:0]  data_d;

  // Latch new geometry at frame end; the bank toggles only when the newly
  // sampled swap enable is set, otherwise it is pinned to bank A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q     <= '0;
      y0_q     <= '0;
      width_q  <= PIXEL_W'(DEF_WIDTH);
      depth_q  <= LINE_W'(DEF_DEPTH);
      stride_q <= PIXEL_W'(DEF_WIDTH);
      mode_q   <= 1'b0;
      swap_q   <= 1'b0;
      bank_q   <= 1'b0;
    end else if (i_frame_end) begin
      x0_q     <= i_x0;
      y0_q     <= i_y0;
      width_q  <= i_imag_width;
      depth_q  <= i_imag_depth;
      stride_q <= i_stride;
      mode_q   <= i_mode;
      swap_q   <= i_swap_en;
      bank_q   <= i_swap_en ? ~bank_q : 1'b0;
    end
  end

  // Crop/decimation acceptance and row offset; compares are on the relative
  // coordinates so x0+width can never wrap.
  always_comb begin
    rx        = i_pixel - x0_q;
    ry        = i_line - y0_q;
    accept    = i_we && (i_pixel >= x0_q) && (rx < width_q) &&
                (i_line >= y0_q) && (ry < depth_q) &&
                (!mode_q || (!rx[0] && !ry[0]));
    col_d     = mode_q ? (rx >> 1) : rx;
    ry_eff    = mode_q ? (ry >> 1) : ry;
    row_off_d = ADDR_W'(ry_eff) * ADDR_W'(stride_q);
  end

  // Stage 1 register; the bank is captured here so in-flight pixels keep it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      bank1_q   <= 1'b0;
      data1_q   <= '0;
      col_q     <= '0;
      row_off_q <= '0;
      fe1_q     <= 1'b0;
    end else begin
      v1_q      <= accept;
      bank1_q   <= bank_q;
      data1_q   <= i_data;
      col_q     <= col_d;
      row_off_q <= row_off_d;
      fe1_q     <= i_frame_end;
    end
  end

  // Final address, bank-overflow detection, write counting and frame status.
  always_comb begin
    off      = row_off_q + ADDR_W'(col_q);
    in_range = off < BANK_B_BASE;
    we_d     = v1_q && in_range;
    ovf_set  = v1_q && !in_range;
    addr_d   = '0;
    data_d   = '0;
    if (we_d) begin
      addr_d = off + (bank1_q ? BANK_B_BASE : '0);
      data_d = data1_q;
    end
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + ADDR_W'(we_d);
    cnt_d       = cnt_inc;
    pix_count_d = pix_count_q;
    // the write registered on this edge is the last one of the ending frame
    if (fe1_q) begin
      pix_count_d = cnt_inc;
      cnt_d       = '0;
    end
    ovf_d = ovf_set || (ovf_q && !fe1_q);
  end

  // Stage 2 / output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      pix_count_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      done_q      <= fe1_q;
      cnt_q       <= cnt_d;
      pix_count_q <= pix_count_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_we         = we_q;
  assign o_addr       = addr_q;
  assign o_data       = data_q;
  assign o_wr_bank    = bank_q;
  assign o_rd_bank    = swap_q & ~bank_q;
  assign o_frame_done = done_q;
  assign o_pix_count  = pix_count_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_frame_addr_gen.sv
// Directed bench for frame_addr_gen with hand-computed expected values.
module tb_frame_addr_gen;
  localparam int DATA_W  = 12;
  localparam int LINE_W  = 9;
  localparam int PIXEL_W = 10;
  localparam int ADDR_W  = 18;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_we, i_frame_end, i_mode, i_swap_en;
  logic [DATA_W-1:0]  i_data;
  logic [LINE_W-1:0]  i_line, i_y0, i_imag_depth;
  logic [PIXEL_W-1:0] i_pixel, i_x0, i_imag_width, i_stride;
  logic               o_we, o_wr_bank, o_rd_bank, o_frame_done, o_overflow;
  logic [DATA_W-1:0]  o_data;
  logic [ADDR_W-1:0]  o_addr, o_pix_count;

  int checks = 0;
  int errors = 0;

  frame_addr_gen dut (
    .clk(clk), .rst_n(rst_n), .i_we(i_we), .i_data(i_data), .i_line(i_line),
    .i_pixel(i_pixel), .i_frame_end(i_frame_end), .i_x0(i_x0), .i_y0(i_y0),
    .i_imag_width(i_imag_width), .i_imag_depth(i_imag_depth),
    .i_stride(i_stride), .i_mode(i_mode), .i_swap_en(i_swap_en),
    .o_we(o_we), .o_data(o_data), .o_addr(o_addr), .o_wr_bank(o_wr_bank),
    .o_rd_bank(o_rd_bank), .o_frame_done(o_frame_done),
    .o_pix_count(o_pix_count), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg(input int x0, input int y0, input int w, input int d,
                     input int s, input bit m, input bit sw);
    i_x0 = PIXEL_W'(x0); i_y0 = LINE_W'(y0);
    i_imag_width = PIXEL_W'(w); i_imag_depth = LINE_W'(d);
    i_stride = PIXEL_W'(s); i_mode = m; i_swap_en = sw;
  endtask

  // present one pixel for one cycle
  task automatic drive(input int l, input int p, input int dat, input bit fe);
    i_we = 1'b1; i_line = LINE_W'(l); i_pixel = PIXEL_W'(p);
    i_data = DATA_W'(dat); i_frame_end = fe;
    tick();
    i_we = 1'b0; i_frame_end = 1'b0;
  endtask

  // single pixel, checked at its 2-cycle latency point
  task automatic pix(input string tag, input int l, input int p, input int dat,
                     input bit exp_we, input int exp_addr);
    drive(l, p, dat, 1'b0);
    chk({tag, "_lat1"}, 32'(o_we), 0);
    tick();
    chk({tag, "_we"}, 32'(o_we), 32'(exp_we));
    chk({tag, "_addr"}, 32'(o_addr), exp_addr);
    chk({tag, "_data"}, 32'(o_data), exp_we ? dat : 0);
  endtask

  task automatic frame_end(input string tag, input int exp_cnt);
    i_frame_end = 1'b1;
    tick();
    i_frame_end = 1'b0;
    chk({tag, "_done_early"}, 32'(o_frame_done), 0);
    tick();
    chk({tag, "_done"}, 32'(o_frame_done), 1);
    chk({tag, "_count"}, 32'(o_pix_count), exp_cnt);
    tick();
    chk({tag, "_done_once"}, 32'(o_frame_done), 0);
  endtask

  initial begin
    rst_n = 1'b0; i_we = 1'b0; i_frame_end = 1'b0; i_data = '0;
    i_line = '0; i_pixel = '0;
    cfg(0, 0, 320, 240, 320, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_we", 32'(o_we), 0);
    chk("rst_addr", 32'(o_addr), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_wr_bank", 32'(o_wr_bank), 0);
    chk("rst_rd_bank", 32'(o_rd_bank), 0);
    chk("rst_done", 32'(o_frame_done), 0);
    chk("rst_count", 32'(o_pix_count), 0);
    chk("rst_ovf", 32'(o_overflow), 0);
    #3 rst_n = 1'b1;
    tick();

    // defaults: stride 320 -> 2*320+5
    pix("t1", 2, 5, 'h123, 1'b1, 645);
    chk("t1_bank", 32'(o_wr_bank), 0);

    // crop window
    cfg(10, 4, 100, 50, 100, 1'b0, 1'b0);
    frame_end("f1", 1);
    pix("t2_left", 4, 9, 'h111, 1'b0, 0);
    pix("t2_origin", 4, 10, 'hABC, 1'b1, 0);
    pix("t2_corner", 53, 109, 'h5A5, 1'b1, 4999);
    pix("t2_right", 53, 110, 'h222, 1'b0, 0);

    // 2x decimation
    cfg(0, 0, 320, 240, 160, 1'b1, 1'b0);
    frame_end("f2", 2);
    pix("t3_odd", 0, 1, 'h333, 1'b0, 0);
    pix("t3_even", 4, 6, 'h444, 1'b1, 323);
    frame_end("f3", 1);
    for (int r = 0; r < 240; r += 2) begin
      for (int p = 0; p < 320; p += 2) begin
        i_we = 1'b1; i_line = LINE_W'(r); i_pixel = PIXEL_W'(p);
        i_data = DATA_W'(r + p);
        tick();
      end
    end
    i_we = 1'b0;
    tick(); tick();

    // double buffering
    cfg(0, 0, 320, 240, 320, 1'b0, 1'b1);
    frame_end("f4", 19200);
    chk("t4_bank_b", 32'(o_wr_bank), 1);
    chk("t4_rd_a", 32'(o_rd_bank), 0);
    frame_end("f5", 0);
    chk("t4_bank_a", 32'(o_wr_bank), 0);
    chk("t4_rd_b", 32'(o_rd_bank), 1);
    drive(0, 0, 'h055, 1'b1);
    tick();
    chk("t4_fe_we", 32'(o_we), 1);
    chk("t4_fe_addr", 32'(o_addr), 0);
    chk("t4_fe_done", 32'(o_frame_done), 1);
    chk("t4_fe_count", 32'(o_pix_count), 1);
    chk("t4_fe_bank", 32'(o_wr_bank), 1);
    drive(0, 0, 'h066, 1'b0);
    chk("t4_done_once", 32'(o_frame_done), 0);
    tick();
    chk("t4_b_we", 32'(o_we), 1);
    chk("t4_b_addr", 32'(o_addr), 76800);
    chk("t4_b_data", 32'(o_data), 'h066);
    chk("t4_b_rd", 32'(o_rd_bank), 0);
    chk("t4_b_done", 32'(o_frame_done), 0);

    // bank overflow: 192*400 = 76800
    cfg(0, 0, 400, 240, 400, 1'b0, 1'b0);
    frame_end("f7", 1);
    chk("t5_bank", 32'(o_wr_bank), 0);
    chk("t5_rd", 32'(o_rd_bank), 0);
    drive(192, 0, 'h777, 1'b0);
    tick();
    chk("t5_we", 32'(o_we), 0);
    chk("t5_addr", 32'(o_addr), 0);
    chk("t5_ovf", 32'(o_overflow), 1);
    tick(); tick();
    chk("t5_ovf_hold", 32'(o_overflow), 1);
    i_frame_end = 1'b1;
    tick();
    i_frame_end = 1'b0;
    chk("t5_ovf_pre_done", 32'(o_overflow), 1);
    tick();
    chk("t5_done", 32'(o_frame_done), 1);
    chk("t5_count", 32'(o_pix_count), 0);
    tick();
    chk("t5_ovf_clear", 32'(o_overflow), 0);

    // async reset with a pixel in stage 1
    i_we = 1'b1; i_line = 9'd2; i_pixel = 10'd5; i_data = 12'h0F0;
    tick();
    i_pixel = 10'd6;
    tick();
    i_we = 1'b0;
    chk("t6_pre_we", 32'(o_we), 1);
    chk("t6_pre_addr", 32'(o_addr), 805);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_we", 32'(o_we), 0);
    chk("t6_async_addr", 32'(o_addr), 0);
    tick(); tick();
    #3 rst_n = 1'b1;
    tick();
    chk("t6_post_we0", 32'(o_we), 0);
    tick();
    chk("t6_post_we1", 32'(o_we), 0);
    chk("t6_post_count", 32'(o_pix_count), 0);
    pix("t6_defaults", 2, 5, 'h0A5, 1'b1, 645);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
